// File: rtl/dpi_stream_sequencer.sv
// Front-end sequencer for the per-regex DPI matchers.
// Maps each packet's flow key to a 6-bit stream id through a 64-entry flow table, then
// drives the matcher-bank control sequence: load_state, guard gap, payload chars,
// drain gap and eop.
module dpi_stream_sequencer #(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned LOAD_GAP = 2,
    parameter int unsigned EOP_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [KEY_W-1:0] in_key,
    input  logic [63:0]      en_mask,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             load_state,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic             enable,
    output logic             eop,
    output logic             evict,
    output logic             drop_err
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLookup = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StGap    = 3'd3;
    localparam logic [2:0] StData   = 3'd4;
    localparam logic [2:0] StDrain  = 3'd5;
    localparam logic [2:0] StEop    = 3'd6;

    // The counter starts at 1 on entry, so the last value of each gap is GAP-1.
    localparam logic [3:0] GapLast   = 4'(LOAD_GAP - 1);
    localparam logic [3:0] DrainLast = 4'(EOP_GAP - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [KEY_W-1:0] key_q;
    logic [63:0]      tbl_vld_q;
    logic [KEY_W-1:0] tbl_key_q [64];
    logic [5:0]       alloc_ptr_q;
    logic [5:0]       sid_q;
    logic             new_q;
    logic             evict_q;
    logic             enable_q;
    logic             run_q;
    logic             hit;
    logic [5:0]       hit_idx;
    logic             idle_drop;

    // Parallel key compare; descending scan leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == key_q)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    // run_q keeps in_rdy/drop_err low while reset is asserted and the cycle after.
    assign idle_drop = (state_q == StIdle) && run_q && in_vld && !in_sop;

    // Next-state and gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            StIdle: begin
                if (run_q && in_vld && in_sop) begin
                    state_d = StLookup;
                end
            end
            StLookup: state_d = StLoad;
            StLoad: begin
                state_d   = StGap;
                gap_cnt_d = 4'd1;
            end
            StGap: begin
                if (gap_cnt_q >= GapLast) begin
                    state_d   = StData;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            StData: begin
                if (in_vld && in_eop) begin
                    state_d   = StDrain;
                    gap_cnt_d = 4'd1;
                end
            end
            StDrain: begin
                if (gap_cnt_q >= DrainLast) begin
                    state_d   = StEop;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            StEop:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM, key capture, lookup result, table valid bits and allocation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gap_cnt_q   <= '0;
            key_q       <= '0;
            tbl_vld_q   <= '0;
            alloc_ptr_q <= '0;
            sid_q       <= '0;
            new_q       <= 1'b0;
            evict_q     <= 1'b0;
            enable_q    <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            run_q     <= 1'b1;
            evict_q   <= 1'b0;
            if (state_q == StIdle && run_q && in_vld && in_sop) begin
                key_q <= in_key;
            end
            if (state_q == StLookup) begin
                sid_q   <= hit ? hit_idx : alloc_ptr_q;
                new_q   <= !hit;
                evict_q <= !hit && tbl_vld_q[alloc_ptr_q];
            end
            if (state_q == StLoad) begin
                enable_q <= en_mask[sid_q];
                if (new_q) begin
                    tbl_vld_q[sid_q] <= 1'b1;
                    alloc_ptr_q      <= alloc_ptr_q + 6'd1;
                end
            end
        end
    end

    // Key storage needs no reset; entries are qualified by tbl_vld_q.
    always_ff @(posedge clk) begin
        if (state_q == StLoad && new_q) begin
            tbl_key_q[sid_q] <= key_q;
        end
    end

    // Output decode; enable reads the mask live during LOAD, then holds the sample.
    always_comb begin
        in_rdy        = (state_q == StData) || idle_drop;
        drop_err      = idle_drop;
        char_in       = (state_q == StData) ? in_data : 8'h00;
        char_in_vld   = (state_q == StData) && in_vld;
        load_state    = (state_q == StLoad);
        eop           = (state_q == StEop);
        stream_id     = sid_q;
        new_stream_id = new_q;
        evict         = evict_q;
        enable        = (state_q == StLoad) ? en_mask[sid_q] : enable_q;
    end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Scoreboard bench for dpi_stream_sequencer: the driver queues expected matcher events,
// an independent monitor pops and compares them as the DUT emits them.
module tb_dpi_stream_sequencer;

    localparam int unsigned KEY_W    = 32;
    localparam int          LOAD_GAP = 2;
    localparam int          EOP_GAP  = 4;
    localparam int K_LOAD = 0;
    localparam int K_CHAR = 1;
    localparam int K_EOP  = 2;
    localparam int K_DROP = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vld, in_rdy, in_sop, in_eop;
    logic [7:0]       in_data;
    logic [KEY_W-1:0] in_key;
    logic [63:0]      en_mask;
    logic [7:0]       char_in;
    logic             char_in_vld, load_state, new_stream_id, enable, eop, evict, drop_err;
    logic [5:0]       stream_id;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [5:0] sid;
        logic       nw;
        logic       en;
        logic       ev;
        int         rk;   // 1: delay from last issued beat, 2: delay from previous event
        int         dly;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          prev_cyc = 0;
    bit          use_mid = 1'b0;
    logic [63:0] mid_mask = '0;

    dpi_stream_sequencer #(
        .KEY_W   (KEY_W),
        .LOAD_GAP(LOAD_GAP),
        .EOP_GAP (EOP_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_key       (in_key),
        .en_mask      (en_mask),
        .char_in      (char_in),
        .char_in_vld  (char_in_vld),
        .load_state   (load_state),
        .stream_id    (stream_id),
        .new_stream_id(new_stream_id),
        .enable       (enable),
        .eop          (eop),
        .evict        (evict),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: one event per cycle at most; compare it with the head of the queue.
    exp_t e;
    int   kind;
    int   dt;
    bit   ok;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cyc = cyc;
            end else begin
                kind = -1;
                if (load_state)       kind = K_LOAD;
                else if (char_in_vld) kind = K_CHAR;
                else if (eop)         kind = K_EOP;
                else if (drop_err)    kind = K_DROP;
                if (evict && !load_state) begin
                    checks++;
                    errors++;
                    $display("FAIL evict_stray got evict=1 outside load_state required 0");
                end
                if (kind >= 0) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event got kind=%0d at cycle %0d required none",
                                 kind, cyc);
                    end else begin
                        e  = q.pop_front();
                        dt = (e.rk == 1) ? (cyc - issue_cyc) : (cyc - prev_cyc);
                        ok = (e.kind == kind) && (dt == e.dly);
                        if (kind == K_LOAD)
                            ok = ok && (stream_id == e.sid) && (new_stream_id == e.nw) &&
                                 (enable == e.en) && (evict == e.ev);
                        if (kind == K_CHAR)
                            ok = ok && (char_in == e.data);
                        if (kind == K_EOP)
                            ok = ok && (stream_id == e.sid) && (new_stream_id == e.nw) &&
                                 (enable == e.en);
                        if (!ok) begin
                            errors++;
                            $display({"FAIL event got kind=%0d data=%h sid=%0d new=%0b en=%0b ",
                                      "ev=%0b dt=%0d required kind=%0d data=%h sid=%0d new=%0b ",
                                      "en=%0b ev=%0b dt=%0d"},
                                     kind, char_in, stream_id, new_stream_id, enable, evict, dt,
                                     e.kind, e.data, e.sid, e.nw, e.en, e.ev, e.dly);
                        end
                    end
                    prev_cyc = cyc;
                end
            end
        end
    end

    task automatic push_ev(input int k, input logic [7:0] d, input logic [5:0] sid,
                           input logic nw, input logic en, input logic ev,
                           input int rk, input int dly);
        exp_t x;
        x.kind = k; x.data = d; x.sid = sid; x.nw = nw; x.en = en; x.ev = ev;
        x.rk = rk; x.dly = dly;
        q.push_back(x);
    endtask

    task automatic check_zero(input string name);
        logic [21:0] v;
        v = {in_rdy, char_in, char_in_vld, load_state, stream_id, new_stream_id, enable, eop,
             evict, drop_err};
        checks++;
        if (v != '0) begin
            errors++;
            $display("FAIL %s outputs got %h required 0", name, v);
        end
    endtask

    // Wait (bounded) for all queued events, then align to just after a rising edge.
    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d required 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic s, input logic eb,
                              input logic [KEY_W-1:0] k);
        int n = 0;
        in_vld = 1'b1; in_data = d; in_sop = s; in_eop = eb; in_key = k;
        issue_cyc = cyc;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout got in_rdy=0 required 1");
        end
        @(posedge clk); #1;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // Packet of nb (1..3) bytes; g1/g2 are idle cycles before beats 1 and 2.
    task automatic send_pkt(input logic [KEY_W-1:0] k, input int nb,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int g1, input int g2, input logic [5:0] sid,
                            input logic nw, input logic en, input logic ev);
        logic [7:0] b[3];
        int         g[3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        g[0] = 0;  g[1] = g1; g[2] = g2;
        wait_idle();
        push_ev(K_LOAD, 8'h00, sid, nw, en, ev, 1, 2);
        for (int i = 0; i < nb; i++)
            push_ev(K_CHAR, b[i], sid, nw, en, ev, 2, (i == 0) ? LOAD_GAP : 1 + g[i]);
        push_ev(K_EOP, 8'h00, sid, nw, en, ev, 2, EOP_GAP);
        for (int i = 0; i < nb; i++) begin
            repeat (g[i]) begin
                @(posedge clk); #1;
            end
            drive_beat(b[i], i == 0, i == nb - 1, k);
            if (i == 0 && use_mid) en_mask = mid_mask;
        end
    endtask

    initial begin
        in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h5A; in_key = '0;
        en_mask = 64'h1;
        #12;
        check_zero("reset_state");
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First allocation, hit on the same key, second allocation.
        send_pkt(32'hA, 3, 8'h11, 8'h22, 8'h33, 0, 0, 6'd0, 1'b1, 1'b1, 1'b0);
        send_pkt(32'hA, 1, 8'h44, 8'h00, 8'h00, 0, 0, 6'd0, 1'b0, 1'b1, 1'b0);
        send_pkt(32'hB, 2, 8'h55, 8'h66, 8'h00, 0, 0, 6'd1, 1'b1, 1'b0, 1'b0);

        // Fill entries 2..63, then the 65th distinct key wraps onto entry 0 and evicts.
        for (int i = 0; i < 63; i++)
            send_pkt(32'h1000 + i, 1, 8'(i), 8'h00, 8'h00, 0, 0, 6'((2 + i) % 64), 1'b1,
                     (i == 62), (i == 62));
        // Key A was overwritten: new allocation on entry 1, evicting key B.
        send_pkt(32'hA, 1, 8'h99, 8'h00, 8'h00, 0, 0, 6'd1, 1'b1, 1'b0, 1'b1);

        // Enable sampled at LOAD; mask cleared after the first beat must not matter.
        wait_idle();
        en_mask = 64'h2; mid_mask = '0; use_mid = 1'b1;
        send_pkt(32'hA, 3, 8'hC1, 8'hC2, 8'hC3, 0, 0, 6'd1, 1'b0, 1'b1, 1'b0);
        use_mid = 1'b0;

        // Non-sop beat in IDLE is dropped with a drop_err pulse only.
        wait_idle();
        push_ev(K_DROP, 8'h00, 6'd0, 1'b0, 1'b0, 1'b0, 1, 0);
        drive_beat(8'hEE, 1'b0, 1'b0, 32'h0);

        // Single-beat sop+eop packet; key B misses and evicts entry 2.
        send_pkt(32'hB, 1, 8'hD7, 8'h00, 8'h00, 0, 0, 6'd2, 1'b1, 1'b0, 1'b1);

        // in_vld gaps in DATA are mirrored on char_in_vld.
        wait_idle();
        en_mask = '1;
        send_pkt(32'hA, 3, 8'hA1, 8'hA2, 8'hA3, 2, 1, 6'd1, 1'b0, 1'b1, 1'b0);

        // Reset during DATA: outputs clear at once and the table is emptied.
        wait_idle();
        push_ev(K_LOAD, 8'h00, 6'd3, 1'b1, 1'b1, 1'b1, 1, 2);
        push_ev(K_CHAR, 8'h71, 6'd3, 1'b1, 1'b1, 1'b1, 2, LOAD_GAP);
        push_ev(K_CHAR, 8'h72, 6'd3, 1'b1, 1'b1, 1'b1, 2, 1);
        drive_beat(8'h71, 1'b1, 1'b0, 32'h77);
        drive_beat(8'h72, 1'b0, 1'b0, 32'h77);
        in_vld = 1'b1; in_data = 8'h73;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_data");
        q.delete();
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(32'hA, 1, 8'hB5, 8'h00, 8'h00, 0, 0, 6'd0, 1'b1, 1'b1, 1'b0);

        wait_idle();
        repeat (5) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover got pending=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
